// File: rtl/sevenseg_arbiter.sv
// -----------------------------------------------------------------------------
// sevenseg_arbiter
//
// Time-slicing arbiter sharing one 8-digit seven-segment display among NREQ
// requesters. Ownership is granted round-robin. An owner holding its request
// is preempted only after a full slice of HOLD_MS milliseconds, and only if
// another request is pending. The owner's frame is registered onto d7..d0.
// With no owner, every digit is blank.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   CLK_HZ   clock frequency in Hz
//   HOLD_MS  minimum ownership time in ms before preemption
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   req          per-requester level request
//   frame        requester i frame at [56*i+55 : 56*i]; d7 at [55:49] .. d0 at [6:0]
//   gnt          one-hot grant, zero when idle
//   busy         OR of gnt
//   d7..d0       registered digit fields {blank,dp,dash,hex[3:0]}
// -----------------------------------------------------------------------------
module sevenseg_arbiter #(
  parameter int NREQ    = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int HOLD_MS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*56-1:0] frame,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [6:0]         d7,
  output logic [6:0]         d6,
  output logic [6:0]         d5,
  output logic [6:0]         d4,
  output logic [6:0]         d3,
  output logic [6:0]         d2,
  output logic [6:0]         d1,
  output logic [6:0]         d0
);

  localparam int unsigned NR    = NREQ;
  localparam int unsigned SLICE = HOLD_MS * (CLK_HZ / 1000);
  localparam int          CW    = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam int          IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLICE - 1);
  localparam logic [6:0]    BLANK    = 7'b100_0000;

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;       // last owner; equals the current owner while in OWN
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] pick;
  logic [CW-1:0] cnt;
  logic          hit;
  logic          expired;
  logic          owner_req;
  logic          other_req;
  logic          change;
  logic [55:0]   frame_nxt;
  logic [NREQ-1:0] gnt_nxt;

  // Round-robin scan from ptr+1 wrapping to ptr itself. When preempting, the
  // owner sits at the final scan position, so any other requester wins first.
  always_comb begin
    int unsigned idx;
    hit  = 1'b0;
    pick = ptr;
    idx  = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = (32'(ptr) + k) % NR;
      if (!hit && req[IW'(idx)]) begin
        hit  = 1'b1;
        pick = IW'(idx);
      end
    end
  end

  assign expired   = (cnt >= CNT_LAST);
  assign owner_req = req[ptr];
  assign other_req = |(req & ~gnt);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = OWN;
          ptr_nxt   = pick;
        end
      end
      OWN: begin
        if (!owner_req) begin
          if (hit) ptr_nxt = pick;
          else     state_nxt = IDLE;
        end else if (expired && other_req) begin
          ptr_nxt = pick;
        end
      end
      default: state_nxt = IDLE;
    endcase
    change = (state_nxt == OWN) && ((state == IDLE) || (ptr_nxt != ptr));
  end

  always_comb begin
    gnt_nxt   = '0;
    frame_nxt = {8{BLANK}};
    if (state_nxt == OWN) begin
      gnt_nxt[ptr_nxt] = 1'b1;
      for (int unsigned i = 0; i < NR; i++) begin
        if (IW'(i) == ptr_nxt) frame_nxt = frame[56*i +: 56];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= IW'(NREQ - 1);
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      d7    <= BLANK;
      d6    <= BLANK;
      d5    <= BLANK;
      d4    <= BLANK;
      d3    <= BLANK;
      d2    <= BLANK;
      d1    <= BLANK;
      d0    <= BLANK;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      // Counter saturates at expiry so an uncontested owner keeps the display.
      if (change || state_nxt == IDLE) cnt <= '0;
      else if (!expired)               cnt <= cnt + 1'b1;
      gnt  <= gnt_nxt;
      busy <= (state_nxt == OWN);
      d7   <= frame_nxt[55:49];
      d6   <= frame_nxt[48:42];
      d5   <= frame_nxt[41:35];
      d4   <= frame_nxt[34:28];
      d3   <= frame_nxt[27:21];
      d2   <= frame_nxt[20:14];
      d1   <= frame_nxt[13:7];
      d0   <= frame_nxt[6:0];
    end
  end

endmodule

// File: tb/tb_sevenseg_arbiter.sv
module tb_sevenseg_arbiter;

  localparam int NREQ  = 4;
  localparam int SLICE = 12;
  localparam logic [55:0] BLANKS = {8{7'h40}};

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*56-1:0] frame;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [6:0]         d7, d6, d5, d4, d3, d2, d1, d0;

  always #5 clk = ~clk;

  sevenseg_arbiter #(.NREQ(NREQ), .CLK_HZ(4000), .HOLD_MS(3)) dut (
    .clk(clk), .rst(rst), .req(req), .frame(frame), .gnt(gnt), .busy(busy),
    .d7(d7), .d6(d6), .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = idle), last owner, edge counter and
  // the edge on which the current owner was granted.
  int m_owner, m_last, m_edge, m_since;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int ref_next();
    bit contested = 0;
    if (m_owner >= 0 && req[m_owner]) begin
      for (int j = 0; j < NREQ; j++)
        if (j != m_owner && req[j]) contested = 1;
      if (!(contested && (m_edge + 1 - m_since) >= SLICE)) return m_owner;
    end
    for (int k = 1; k <= NREQ; k++) begin
      int j = (m_last + k) % NREQ;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic check_outputs(input int owner, input logic [55:0] exp_d);
    logic [3:0] eg;
    eg = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
    chk("gnt", 64'(gnt), 64'(eg));
    chk("busy", 64'(busy), 64'(owner >= 0));
    chk("digits", 64'({d7, d6, d5, d4, d3, d2, d1, d0}), 64'(exp_d));
  endtask

  task automatic step();
    int nxt;
    logic [NREQ*56-1:0] sh;
    logic [55:0] exp_d;
    nxt = ref_next();
    sh = frame >> (56 * ((nxt < 0) ? 0 : nxt));
    exp_d = (nxt < 0) ? BLANKS : sh[55:0];
    @(posedge clk);
    m_edge++;
    if (nxt >= 0 && nxt != m_owner) begin
      m_since = m_edge;
      m_last  = nxt;
    end
    m_owner = nxt;
    #1;
    check_outputs(m_owner, exp_d);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(-1, BLANKS);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    m_edge = 0;
    m_since = 0;
    req = '0;
    for (int i = 0; i < NREQ * 56; i++) frame[i] = 1'($urandom);
    model_reset();

    // 1: reset state, then idle with no requests
    do_reset();
    for (int i = 0; i < 3; i++) step();

    // 2: single requester, frame change shows one cycle later
    frame[118:112] = 7'h05;
    req = 4'b0100;
    step();
    chk("s2_gnt", 64'(gnt), 64'(4'b0100));
    chk("s2_d0", 64'(d0), 64'(7'h05));
    frame[118:112] = 7'h0A;
    step();
    chk("s2_d0_upd", 64'(d0), 64'(7'h0A));
    req = 4'b0000;
    step();

    // 3: all requesting from reset, 12-cycle round-robin slices
    do_reset();
    req = 4'b1111;
    for (int i = 1; i <= 49; i++) begin
      step();
      if ((i - 1) % SLICE == 0)
        chk("s3_rr", 64'(gnt), 64'(4'b0001 << (((i - 1) / SLICE) % NREQ)));
    end

    // 4: uncontested owner keeps display past the slice
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 40; i++) step();
    chk("s4_hold", 64'(gnt), 64'(4'b0001));
    req = 4'b0011;
    step();
    chk("s4_preempt", 64'(gnt), 64'(4'b0010));

    // 5: owner release hands over without an idle gap, then idle
    req = 4'b1010;
    for (int i = 0; i < 5; i++) step();
    chk("s5_own1", 64'(gnt), 64'(4'b0010));
    req = 4'b1000;
    step();
    chk("s5_handover", 64'(gnt), 64'(4'b1000));
    req = 4'b0000;
    step();
    chk("s5_idle", 64'(gnt), 64'(4'b0000));
    chk("s5_blank", 64'({d7, d6, d5, d4, d3, d2, d1, d0}), 64'(BLANKS));

    // 6: asynchronous reset mid-slice
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) step();
    chk("s6_own2", 64'(gnt), 64'(4'b0100));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("s6_async_gnt", 64'(gnt), 64'(4'b0000));
    chk("s6_async_busy", 64'(busy), 64'(1'b0));
    chk("s6_async_blank", 64'({d7, d6, d5, d4, d3, d2, d1, d0}), 64'(BLANKS));
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("s6_first", 64'(gnt), 64'(4'b0001));

    // 7: randomized requests and frames against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) req[$urandom_range(0, NREQ - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0)
        for (int b = 0; b < NREQ * 56; b++) frame[b] = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_arbiter.md
Name: sevenseg_arbiter

Overview:
Time-slicing arbiter that shares one 8-digit display (the sevenseg_ctl d7..d0 inputs) among NREQ requesters. Each requester presents a full 8-digit frame and a request. The block grants one owner at a time in round-robin order, enforces a minimum hold time before preemption, and drives the registered frame of the owner to the display controller. With no owner, the display is blanked.

Parameters:
NREQ, 4, number of requesters (2..8)
CLK_HZ, 100_000_000, clock frequency in Hz
HOLD_MS, 1000, time slice in ms; owner is preempted only after this time and only if another request is pending

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  NREQ  request per requester, level-sensitive, held while display wanted
frame  input  NREQ*56  frame of requester i at [56*i+55 : 56*i]; within a frame, [55:49]=d7 down to [6:0]=d0; 7-bit digit format {blank,dp,dash,hex[3:0]}
gnt  output  NREQ  one-hot grant, all zero when idle
busy  output  1  high when some requester owns the display (OR of gnt)
d7,d6,d5,d4,d3,d2,d1,d0  output  7 each  digit fields to sevenseg_ctl

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async): gnt=0, busy=0, every d* = 7'b100_0000 (blank). Slice counter = 0. Last-owner pointer = NREQ-1, so requester 0 wins first.
- States:
  - IDLE: gnt=0.
  - OWN: exactly one gnt bit set.
- All outputs are registered and update on the same rising edge.
- Next-owner selection, evaluated every cycle:
  - IDLE with any req high: winner is the first set req scanning last_owner+1, +2, ... modulo NREQ. Go to OWN.
  - OWN and owner's req low: same scan. If no req is high, go to IDLE. Otherwise hand over directly with no idle cycle.
  - OWN, owner's req high, slice expired, and some other req high: winner is the first other requester in scan order from owner+1. The owner is considered last.
  - OWN, owner's req high, and (slice not expired or no other req high): keep the owner. The slice counter saturates at expiry; the owner keeps the display indefinitely while uncontested.
- On every grant change, including the IDLE->OWN entry:
  - last_owner <= new owner.
  - The slice counter clears to 0 on the same edge.
  - Re-grant of the same index is not a change.
- Slice counter:
  - Increments each cycle in OWN.
  - Expired when count >= HOLD_MS*(CLK_HZ/1000)-1, i.e. after HOLD_MS*CLK_HZ/1000 cycles of ownership.
  - Width is sized by $clog2 of that product.
- Display data:
  - Each cycle, d* <= frame slice of the next owner.
  - If the next state is IDLE, d* <= blank (7'b100_0000).
  - A frame change by the owner appears one cycle later.
  - gnt and d* always refer to the same requester in the same cycle.
- Simultaneous events: owner release and new requests on the same cycle resolve in one edge via the scan above. A requester raising and dropping req within one cycle is granted only if sampled high.
- A non-owner dropping req has no effect. The bench must drive frames only with legal values; no checking is done.
- Reset mid-ownership: immediate blank, gnt=0, and pointer returns to NREQ-1.

Test Plan:
Bench parameters for all scenarios: NREQ=4, CLK_HZ=4000, HOLD_MS=3, so one slice = 12 cycles.
1. Reset, then req=0000 -> gnt=0000, busy=0, all d*=7'h40. After reset release with no request, no change.
2. req=0100, frame2 d0=7'h05 -> after 1 edge gnt=0100, busy=1, d0=7'h05. Change frame2 d0 to 7'h0A -> d0=7'h0A one cycle later.
3. req=1111 held from reset -> gnt sequence 0001,0010,0100,1000,0001. Each grant lasts exactly 12 cycles. d* tracks the matching frame on the same cycle as gnt.
4. Owner 0 alone holds req for 40 cycles -> gnt stays 0001 (no preemption). Raise req[1] at cycle 40 -> gnt=0010 on the next edge (slice already expired).
5. Owner 1 drops req after 5 cycles while req[3]=1 -> gnt goes 0010 -> 1000 in one edge with no idle gap. Owner 3 drops req with nothing pending -> gnt=0000, d*=7'h40.
6. Assert rst mid-slice while gnt=0100 -> outputs blank immediately (asynchronously). After release with req=1111, gnt=0001 first.
